rgb_expand: RTL
===============

Name: rgb_expand

Overview:
- Inverse of the marker-detect threshold compressor: takes the 3-bit per-pixel compressed stream ({blue,green,red} above-threshold flags) and re-expands each pixel to full RGB for debug display or overlay.
- Each channel maps to a programmable "on" or "off" level.
- Buffers input in a small FIFO with a valid/ready handshake on both sides, and marks end-of-line on the output stream.

Parameters:
- COLOUR_DEPTH, 8, bits per colour channel.
- FIFO_DEPTH, 16, compressed-pixel FIFO entries; power of two, at least 2.
- LINE_WIDTH, 640, output pixels per line, used for eol_out.
- ON_LEVEL, (1<<COLOUR_DEPTH)-1, reset value of all three on-levels.
- OFF_LEVEL, 0, reset value of all three off-levels.

Ports:
- clk_in  input  1  clock, all logic on rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- compressed_in  input  3  bit0 red, bit1 green, bit2 blue flag.
- valid_in  input  1  compressed_in valid.
- ready_out  output  1  FIFO can accept.
- cfg_we_in  input  1  level register write strobe.
- cfg_sel_in  input  3  [1:0] channel (0 R, 1 G, 2 B, 3 ignored); [2] 1 = on-level, 0 = off-level.
- cfg_data_in  input  COLOUR_DEPTH  level value.
- rgb_out  output  3*COLOUR_DEPTH  {blue,green,red}; red in the low COLOUR_DEPTH bits.
- valid_out  output  1  rgb_out valid.
- ready_in  input  1  downstream accepts.
- eol_out  output  1  current rgb_out pixel is the last pixel of its line.

Behaviour:
- Reset (async assert, synchronous release):
  - FIFO empty, valid_out=0, rgb_out=0, eol_out=0, column counter=0.
  - On-levels = ON_LEVEL, off-levels = OFF_LEVEL.
  - ready_out=0 while rst_n_in low.
- Reset mid-stream discards all FIFO and output contents; no partial pixel survives.
- Input handshake:
  - Accept on a rising edge with valid_in && ready_out.
  - ready_out = !fifo_full, registered; no combinational path from ready_in or valid_in.
  - When full, a simultaneous output pop does not enable a same-cycle push.
- Output stage is a single register:
  - Loads from the FIFO head on an edge where the FIFO is non-empty and (valid_out==0 or ready_in==1).
  - valid_out holds until handshake; rgb_out and eol_out stable while valid_out && !ready_in.
- Latency: pixel accepted at edge N, FIFO empty, output stage free -> valid_out high after edge N+1. No bypass path.
- Throughput: one pixel per cycle sustained when ready_in is held high.
- Expansion:
  - Channel c = flag[c] ? on_level[c] : off_level[c], evaluated when loading the output register.
  - A level write takes effect for pixels loaded on later edges, never for the pixel already held.
- Config writes:
  - cfg_we_in with channel 3 is ignored.
  - A write and a load on the same edge: the load uses the old level.
- eol_out:
  - Column counter advances on each output handshake (valid_out && ready_in).
  - eol_out=1 on the pixel loaded when the counter equals LINE_WIDTH-1; the counter wraps to 0 on that pixel's handshake.
- FIFO pointers are log2(FIFO_DEPTH) bits wide, with a separate occupancy count of log2(FIFO_DEPTH)+1 bits.
- Wrap-around at FIFO_DEPTH is seamless; push and pop on the same edge leave the count unchanged.

Optional Feature:
- Macro: RGB_EXPAND_STATS_EN.
- When defined, adds output port drop_count_out, 16 bits.
  - Counts cycles with valid_in && !ready_out, excluding cycles in reset.
  - Saturates at 16'hFFFF, cleared by reset.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Release reset, push 3'b101 with ready_in=1 -> valid_out high 2 edges later, rgb_out=24'hFF00FF, eol_out=0.
- Write cfg_sel=3'b101 (green on) data 8'h40 and cfg_sel=3'b000 (red off) data 8'h10, then push 3'b010 -> rgb_out=24'h004010.
- ready_in=0, push 17 pixels with FIFO_DEPTH=16:
  - ready_out drops after 16 FIFO pushes plus 1 output-register load.
  - Extra pixels are refused; with RGB_EXPAND_STATS_EN, drop_count_out increments once per refused cycle.
  - Release ready_in -> all accepted pixels emerge in order.
- LINE_WIDTH=4, stream 9 pixels with ready_in=1 -> eol_out high on pixels 4 and 8 only.
- Random ready_in toggling over 1000 pixels -> output sequence equals input sequence, and rgb_out never changes while valid_out && !ready_in.
- Assert rst_n_in mid-stream with FIFO half full -> valid_out=0 immediately; after release the FIFO is empty and the first new pixel appears with latency 2.

Source files
------------

// File: rtl/rgb_expand.sv
// rgb_expand: re-expands a 3-bit {blue,green,red} threshold stream to full RGB.
// Compressed pixels are buffered in a small FIFO. A single output register applies
// programmable per-channel on/off levels and flags the last pixel of each line.
// Optional build macro RGB_EXPAND_STATS_EN adds drop_count_out, a saturating
// count of cycles in which an offered pixel was refused.
module rgb_expand #(
  parameter int unsigned COLOUR_DEPTH = 8,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned LINE_WIDTH   = 640,
  parameter int unsigned ON_LEVEL     = (1 << COLOUR_DEPTH) - 1,
  parameter int unsigned OFF_LEVEL    = 0
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [2:0]                compressed_in,
  input  logic                      valid_in,
  output logic                      ready_out,
  input  logic                      cfg_we_in,
  input  logic [2:0]                cfg_sel_in,
  input  logic [COLOUR_DEPTH-1:0]   cfg_data_in,
  output logic [3*COLOUR_DEPTH-1:0] rgb_out,
  output logic                      valid_out,
`ifdef RGB_EXPAND_STATS_EN
  output logic [15:0]               drop_count_out,
`endif
  input  logic                      ready_in,
  output logic                      eol_out
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned ColW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [CntW-1:0]         CntFull = CntW'(FIFO_DEPTH);
  localparam logic [ColW-1:0]         ColLast = ColW'(LINE_WIDTH - 1);
  localparam logic [COLOUR_DEPTH-1:0] OnRst   = COLOUR_DEPTH'(ON_LEVEL);
  localparam logic [COLOUR_DEPTH-1:0] OffRst  = COLOUR_DEPTH'(OFF_LEVEL);

  logic [2:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [ColW-1:0] col_q, col_d;
  logic            ready_q;
  logic            valid_q;
  logic            eol_q;
  logic [3*COLOUR_DEPTH-1:0] rgb_q, pix_exp;
  logic [2:0][COLOUR_DEPTH-1:0] on_q, off_q;
  logic push, pop, hs;
  logic [2:0] head;

  assign push = valid_in && ready_q;
  assign hs   = valid_q && ready_in;
  assign pop  = (cnt_q != '0) && (!valid_q || ready_in);
  assign head = mem_q[rd_ptr_q];

  // FIFO pointer, occupancy and line-column next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    col_d    = col_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (hs) col_d = (col_q == ColLast) ? '0 : col_q + 1'b1;
  end

  // Expand the FIFO head with the levels held before this edge's config write
  always_comb begin
    pix_exp = '0;
    for (int c = 0; c < 3; c++) begin
      pix_exp[c*COLOUR_DEPTH +: COLOUR_DEPTH] = head[c] ? on_q[c] : off_q[c];
    end
  end

  // FIFO storage; contents beyond the occupancy count are don't-care
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= compressed_in;
  end

  // FIFO control, registered ready and output stage
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      col_q    <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      rgb_q    <= '0;
      eol_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      // Full is judged on the post-edge count, so a pop never frees a same-cycle push
      ready_q  <= (cnt_d != CntFull);
      if (pop) begin
        valid_q <= 1'b1;
        rgb_q   <= pix_exp;
        // col_d already accounts for the handshake of the pixel being replaced
        eol_q   <= (col_d == ColLast);
      end else if (hs) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Level registers; channel 3 writes are dropped
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      on_q  <= {3{OnRst}};
      off_q <= {3{OffRst}};
    end else if (cfg_we_in && (cfg_sel_in[1:0] != 2'd3)) begin
      if (cfg_sel_in[2]) on_q[cfg_sel_in[1:0]]  <= cfg_data_in;
      else               off_q[cfg_sel_in[1:0]] <= cfg_data_in;
    end
  end

`ifdef RGB_EXPAND_STATS_EN
  logic [15:0] drop_q;

  // Saturating count of refused offers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      drop_q <= '0;
    end else if (valid_in && !ready_q && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count_out = drop_q;
`endif

  assign ready_out = ready_q;
  assign valid_out = valid_q;
  assign rgb_out   = rgb_q;
  assign eol_out   = eol_q;

endmodule
